maze_carver_bt: RTL
===================

Name: maze_carver_bt

Overview:
- Sequential, parametrised maze generator using the binary-tree algorithm.
- Carves one cell per clock into an internal X_MAX*Y_MAX cell memory.
- Active area is runtime-sized, up to the compile-time maximum; randomness comes from a seedable 16-bit LFSR.
- Feeds the maze renderer and the player-collision logic through a registered read port; signals completion with a level-held finish.

Parameters:
- X_MAX, 4, maximum maze width in cells (2..64)
- Y_MAX, 4, maximum maze height in cells (2..64)
- XW, 3, width of x_dimension / rd_x; must hold X_MAX
- YW, 3, width of y_dimension / rd_y; must hold Y_MAX

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request generation; sampled only in IDLE
- seed  in  16  LFSR seed, captured on accepted start
- x_dimension  in  XW  active width in cells, captured on accepted start
- y_dimension  in  YW  active height in cells, captured on accepted start
- rd_x  in  XW  read column
- rd_y  in  YW  read row
- rd_data  out  2  cell passages: bit0 = east open (to x+1), bit1 = north open (to y-1; row 0 is top)
- busy  out  1  high while carving
- finish  out  1  high from completion until next accepted start or reset

Behaviour:
- Reset values: busy=0, finish=0, rd_data=0, state=IDLE, lfsr=16'hACE1, W=X_MAX, H=Y_MAX. Cell memory is not cleared by reset.
- Dimension latch on accepted start: W = x_dimension, H = y_dimension. A value of 0 or greater than the maximum clamps to X_MAX / Y_MAX.
- Seed latch on accepted start: lfsr = seed. Seed 0 is replaced by 16'hACE1.
- States:
  - IDLE: start=1 -> CARVE; x=0, y=0, busy=1, finish=0.
  - CARVE: each cycle writes cell (x,y) and advances row-major (x increments; at x=W-1 wrap to x=0, y+1). After writing (W-1,H-1) -> DONE.
  - DONE: one cycle; busy=0, finish=1 -> IDLE.
- Carve rule per cell, written value {north,east}:
  - (0,0)... more precisely the cell at y=0, x=W-1 -> 2'b00.
  - y=0, x<W-1 -> 2'b01.
  - x=W-1, y>0 -> 2'b10.
  - Otherwise lfsr[0]=1 -> 2'b10, lfsr[0]=0 -> 2'b01.
- LFSR: Galois, polynomial x^16+x^14+x^13+x^11+1, mask 16'hB400. Shifts right once per CARVE cycle, after use.
- Latency: start sampled at edge k; the last cell is written at edge k+W*H; finish=1 after edge k+W*H+1. Example: 4x4 -> finish 17 clocks after the start edge.
- Read port: rd_data is registered, 1-cycle latency. Returns 2'b00 if rd_x>=W or rd_y>=H (latched dimensions). Reads are legal at any time; during CARVE they return current memory contents.
- start while busy is ignored. start held high in IDLE re-triggers after each DONE.
- Reset mid-CARVE: next cycle is IDLE, busy=0, finish=0. Partially carved contents are retained but invalid.
- Without the optional feature the result is a perfect maze: exactly W*H-1 open passage bits.

Optional Feature:
- Macro: MAZE_LOOPS_EN.
- When defined: interior cells (y>0, x<W-1) with lfsr[3:1]==3'b000 are written 2'b11, which creates loops. Open-bit count is >= W*H-1.
- When undefined: exactly one passage per non-corner cell, as described above.

Test Plan:
- 4x4, seed 16'h1234, start pulse -> busy for 16 cycles, finish 17 clocks after start; total open bits = 15; row 0 reads 01,01,01,00; column 3 rows 1..3 read 10.
- x_dimension=4, y_dimension=1 -> rd_data 01,01,01,00 for x=0..3; finish 5 clocks after start; rd_y=1 returns 00.
- x_dimension=1, y_dimension=4 -> rd_data 00,10,10,10 for y=0..3.
- x_dimension=0, y_dimension=7 (X_MAX=Y_MAX=4) -> clamps to 4x4, finish at 17 clocks.
- Same seed run twice -> identical memory. Seed 0 -> identical to seed 16'hACE1.
- Reset asserted at cycle 5 of CARVE -> busy=0, finish=0 next cycle. A start pulse during CARVE is ignored (finish timing unchanged).

Source files
------------

// File: rtl/maze_carver_bt.sv
// Binary-tree maze carver: fills an X_MAX*Y_MAX cell memory one cell per clock, with a registered read port.
// Optional MAZE_LOOPS_EN opens both passages on some interior cells, which creates loops.
module maze_carver_bt #(
   parameter int X_MAX = 4,
   parameter int Y_MAX = 4,
   parameter int XW    = 3,
   parameter int YW    = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [15:0]   seed,
   input  logic [XW-1:0] x_dimension,
   input  logic [YW-1:0] y_dimension,
   input  logic [XW-1:0] rd_x,
   input  logic [YW-1:0] rd_y,
   output logic [1:0]    rd_data,
   output logic          busy,
   output logic          finish
);

   localparam int DEPTH = X_MAX * Y_MAX;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [XW-1:0] W_MAX     = XW'(X_MAX);
   localparam logic [YW-1:0] H_MAX     = YW'(Y_MAX);
   localparam logic [15:0]   LFSR_INIT = 16'hACE1;
   localparam logic [15:0]   LFSR_MASK = 16'hB400;

   typedef enum logic [1:0] {IDLE, CARVE, DONE} state_t;

   state_t        state_q, state_d;
   logic [XW-1:0] x_q, w_q, w_sel;
   logic [YW-1:0] y_q, h_q, h_sel;
   logic [15:0]   lfsr_q, lfsr_next;
   logic [1:0]    mem [DEPTH];
   logic [1:0]    cell_val;
   logic          last_col, last_row, last_cell, rd_in_range;
   logic [AW-1:0] wr_addr, rd_addr;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CARVE;
         CARVE:   if (last_cell) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Zero or oversized dimensions fall back to the full memory.
   always_comb begin
      w_sel = x_dimension;
      h_sel = y_dimension;
      if (x_dimension == '0 || x_dimension > W_MAX) w_sel = W_MAX;
      if (y_dimension == '0 || y_dimension > H_MAX) h_sel = H_MAX;
   end

   assign last_col  = (x_q == w_q - XW'(1));
   assign last_row  = (y_q == h_q - YW'(1));
   assign last_cell = last_col && last_row;
   assign lfsr_next = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ LFSR_MASK) : {1'b0, lfsr_q[15:1]};
   assign wr_addr   = AW'(y_q * X_MAX + x_q);

   // Top row can only open east, right column only north; the top-right corner is closed.
   always_comb begin
      cell_val = 2'b01;
      if (y_q == '0) begin
         cell_val = last_col ? 2'b00 : 2'b01;
      end else if (last_col) begin
         cell_val = 2'b10;
      end else begin
         cell_val = lfsr_q[0] ? 2'b10 : 2'b01;
`ifdef MAZE_LOOPS_EN
         if (lfsr_q[3:1] == 3'b000) cell_val = 2'b11;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         busy    <= 1'b0;
         finish  <= 1'b0;
         lfsr_q  <= LFSR_INIT;
         w_q     <= W_MAX;
         h_q     <= H_MAX;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  x_q    <= '0;
                  y_q    <= '0;
                  busy   <= 1'b1;
                  finish <= 1'b0;
                  w_q    <= w_sel;
                  h_q    <= h_sel;
                  lfsr_q <= (seed == 16'h0000) ? LFSR_INIT : seed;
               end
            end
            CARVE: begin
               lfsr_q <= lfsr_next;
               if (last_col) begin
                  x_q <= '0;
                  y_q <= y_q + YW'(1);
               end else begin
                  x_q <= x_q + XW'(1);
               end
               if (last_cell) busy <= 1'b0;
            end
            DONE:    finish <= 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && state_q == CARVE) mem[wr_addr] <= cell_val;
   end

   assign rd_in_range = (rd_x < w_q) && (rd_y < h_q);
   assign rd_addr     = AW'(rd_y * X_MAX + rd_x);

   always_ff @(posedge clk) begin
      if (reset) rd_data <= 2'b00;
      else       rd_data <= rd_in_range ? mem[rd_addr] : 2'b00;
   end

endmodule
